sync_fifo_ext: RTL and testbench
================================

# sync_fifo_ext

Parametrised synchronous FIFO used as the standard buffering element between producer and consumer blocks on the CLOCK_50 domain. It supports any width and any depth, including depths that are not a power of two. It provides a selectable output mode: registered read or first-word-fall-through. It also exposes an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow and underflow error flags.

## Interface
- WIDTH, 32: data width in bits, ≥1.
- DEPTH, 10: number of entries, ≥2, any integer.
- FWFT, 0: output mode. 0 = registered read. 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-1: almost_full asserts when level ≥ AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL.
- Width rules: LW = $clog2(DEPTH+1); PW = max(1, $clog2(DEPTH)).

- CLOCK_50, in, 1: clock. Every register updates on its rising edge.
- RST_N, in, 1: reset, synchronous, active-low.
- flush, in, 1: synchronous clear of the contents.
- data_in, in, WIDTH: write data.
- write, in, 1: write request.
- read, in, 1: read request.
- data_out, out, WIDTH: read data.
- data_valid, out, 1: data_out holds a valid word.
- empty, out, 1: level == 0.
- full, out, 1: level == DEPTH.
- almost_empty, out, 1: level ≤ AE_LEVEL.
- almost_full, out, 1: level ≥ AF_LEVEL.
- level, out, LW: current occupancy.
- overflow, out, 1: sticky. A write was attempted while full.
- underflow, out, 1: sticky. A read was attempted while empty.
- err_clear, in, 1: clears overflow and underflow.

## Operation
- wr_acc = write & ~full. rd_acc = read & ~empty.
  - Both are evaluated on the pre-edge state.
  - A write while full is dropped, even if a read is accepted in the same cycle.
- Level update:
  - wr_acc only: level + 1.
  - rd_acc only: level − 1.
  - Both: level unchanged, and both pointers advance.
- Pointers advance by 1 per accept and wrap from DEPTH−1 to 0 explicitly; there is no modulo-2^PW wrap.
- FWFT=0:
  - On rd_acc, data_out is loaded with the head entry.
  - data_valid is a one-cycle pulse the cycle after rd_acc.
  - data_out holds its value otherwise.
- FWFT=1:
  - data_out = storage[rd_ptr], driven combinationally from the storage read.
  - data_valid = ~empty.
  - A read pops the head; the next word appears in the same cycle the pointer updates.
- flush: pointers and level go to 0 and data_valid goes to 0. Storage contents are not cleared.
  - flush has priority over write and read in the same cycle. Both are ignored.
  - Error flags are not affected by flush.
- Error flags:
  - overflow sets on write & full. underflow sets on read & empty.
  - err_clear clears both.
  - If err_clear coincides with a new error, the set wins.
- Flags are decoded from the registered level, so there are no extra pipeline stages.

## Timing
- Reset is synchronous and applies at the first rising edge with RST_N=0. It has priority over everything, including a mid-burst transfer.
- Reset values:
  - level=0, empty=1, full=0.
  - almost_empty=1, almost_full = (AF_LEVEL==0).
  - data_out=0, data_valid=0.
  - overflow=0, underflow=0.
  - Pointers = 0. Storage does not need to be reset.
- Write to flag update: 1 cycle. empty deasserts the edge after the first wr_acc.
- FWFT=1: the first word is visible on data_out one cycle after its write (write→read-visible latency 1).
- FWFT=0: data is available 1 cycle after rd_acc.
- There is no read-during-write bypass of an empty FIFO in either mode.
- Simultaneous write and read at level==DEPTH: the read is accepted, the write is dropped, overflow is set, and level becomes DEPTH−1.
- Simultaneous write and read at level==0: the write is accepted, the read is rejected, underflow is set, and level becomes 1.

## Structure
- Shared package/header fifo_pkg holds:
  - mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1;
  - the LW/PW width-calculation helper, shared with future FIFO variants.
- Sub-module fifo_ram: a DEPTH×WIDTH storage array with one synchronous write port and one asynchronous read port (rd_addr → rd_data).
  - The top level holds pointers, level, flags, mode logic and error logic.

## Test plan
- Configuration for all scenarios: WIDTH=8, DEPTH=5 (not a power of two), AF_LEVEL=4, AE_LEVEL=1.
- FWFT=0: write 0x11,0x22,0x33,0x44,0x55 → full=1 and level=5 after the 5th edge. Then 5 reads → data_out 0x11..0x55, each with a data_valid pulse one cycle after the read. empty=1 at the end.
- Wrap-around: run 3 cycles of 4 writes + 4 reads, with data incrementing from 0x00 → output order is exact, pointers wrap at 4→0, and level never exceeds 4.
- Full boundary: from full, assert write=1 with data 0xAA and read=1 → level=4, overflow=1, and 0xAA is never read out. err_clear → overflow=0.
- Empty boundary: from empty, assert read alone → underflow=1 and level stays 0. Then assert write=1 (0x5A) and read=1 together → level=1 and underflow stays 1.
- FWFT=1: write 0x77 → the next cycle data_out=0x77, data_valid=1 and almost_empty=1. Read → empty=1 and data_valid=0 on the following cycle.
- Flush/reset: with level=3, assert flush together with write → level=0 and empty=1, the write is ignored, and the error flags are unchanged. Pull RST_N low mid-burst → all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: output-mode
// constants and the level/pointer width helpers.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int fifo_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: addresses 0..depth-1, never narrower than one bit.
    function automatic int fifo_pw(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic             CLOCK_50,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge CLOCK_50) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: combinational lookup of the addressed entry.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo_ext.sv
// Parametrised synchronous FIFO with registered or first-word-fall-through
// output, occupancy count, programmable almost flags, flush and sticky
// overflow/underflow error flags. Depth need not be a power of two.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 10,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int LW      = fifo_lw(DEPTH),
    localparam int PW      = fifo_pw(DEPTH)
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clear
);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    // Accept decisions from pre-edge state; flush suppresses both transfers.
    always_comb begin
        wr_acc = write & ~full  & ~flush;
        rd_acc = read  & ~empty & ~flush;
    end

    // Status flags decoded directly from the registered level.
    always_comb begin
        empty        = (level_q == '0);
        full         = (level_q == LW'(DEPTH));
        almost_empty = (int'(level_q) <= AE_LEVEL);
        almost_full  = (int'(level_q) >= AF_LEVEL);
        level        = level_q;
    end

    // Pointers and level: explicit wrap at DEPTH-1 so odd depths work.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky error flags: a new error outranks a coincident clear; flush
    // leaves them alone.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (write & full)  | (overflow  & ~err_clear);
            underflow <= (read  & empty) | (underflow & ~err_clear);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .we       (wr_acc),
        .wr_addr  (wr_ptr),
        .wr_data  (data_in),
        .rd_addr  (rd_ptr),
        .rd_data  (rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head entry is presented combinationally while the FIFO is non-empty.
        always_comb begin
            data_out   = rd_data;
            data_valid = ~empty;
        end
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             dvalid_q;

        // Registered read: load the head on an accepted read, pulse valid.
        always_ff @(posedge CLOCK_50) begin
            if (!RST_N) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                if (rd_acc) begin
                    dout_q <= rd_data;
                end
                dvalid_q <= rd_acc;
            end
        end

        // Drive outputs from the read register.
        always_comb begin
            data_out   = dout_q;
            data_valid = dvalid_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench: a registered-read and an FWFT instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_ext;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int LW = fifo_lw(D);

    logic          CLOCK_50 = 1'b0;
    logic          RST_N    = 1'b0;
    logic          flush    = 1'b0;
    logic [W-1:0]  data_in  = '0;
    logic          write    = 1'b0;
    logic          read     = 1'b0;
    logic          err_clear = 1'b0;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_dv, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic          f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [LW-1:0] s_level, f_level;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    bit           m_dv, m_ovf, m_udf;

    always #10 CLOCK_50 = ~CLOCK_50;

    sync_fifo_ext #(
        .WIDTH(W), .DEPTH(D), .FWFT(FIFO_MODE_STD), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_std (
        .CLOCK_50(CLOCK_50), .RST_N(RST_N), .flush(flush), .data_in(data_in),
        .write(write), .read(read), .data_out(s_dout), .data_valid(s_dv),
        .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .level(s_level), .overflow(s_ovf), .underflow(s_udf), .err_clear(err_clear)
    );

    sync_fifo_ext #(
        .WIDTH(W), .DEPTH(D), .FWFT(FIFO_MODE_FWFT), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_fwft (
        .CLOCK_50(CLOCK_50), .RST_N(RST_N), .flush(flush), .data_in(data_in),
        .write(write), .read(read), .data_out(f_dout), .data_valid(f_dv),
        .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .level(f_level), .overflow(f_ovf), .underflow(f_udf), .err_clear(err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        bit wa, ra, was_full, was_empty;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (!RST_N) begin
            mq.delete();
            m_dout = '0;
            m_dv   = 0;
            m_ovf  = 0;
            m_udf  = 0;
            return;
        end
        m_ovf = (write && was_full)  || (m_ovf && !err_clear);
        m_udf = (read  && was_empty) || (m_udf && !err_clear);
        if (flush) begin
            mq.delete();
            m_dv = 0;
            return;
        end
        wa = write && !was_full;
        ra = read  && !was_empty;
        m_dv = ra;
        if (ra) m_dout = mq.pop_front();
        if (wa) mq.push_back(data_in);
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("std_level", 32'(s_level), n);
        chk("fwft_level", 32'(f_level), n);
        chk("empty", 32'(s_empty), 32'(n == 0));
        chk("full", 32'(s_full), 32'(n == D));
        chk("almost_empty", 32'(s_ae), 32'(n <= AE));
        chk("almost_full", 32'(s_af), 32'(n >= AF));
        chk("fwft_flags", 32'({f_empty, f_full, f_ae, f_af}),
            32'({n == 0, n == D, n <= AE, n >= AF}));
        chk("overflow", 32'({s_ovf, f_ovf}), 32'({m_ovf, m_ovf}));
        chk("underflow", 32'({s_udf, f_udf}), 32'({m_udf, m_udf}));
        chk("std_dout", 32'(s_dout), 32'(m_dout));
        chk("std_dvalid", 32'(s_dv), 32'(m_dv));
        chk("fwft_dvalid", 32'(f_dv), 32'(n != 0));
        if (n != 0) chk("fwft_dout", 32'(f_dout), 32'(mq[0]));
    endtask

    // One clock: drive inputs, let the edge happen, check mid-cycle.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r,
                        input bit f = 0, input bit ec = 0, input bit rn = 1);
        write = w; data_in = d; read = r; flush = f; err_clear = ec; RST_N = rn;
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        check_all();
    endtask

    initial begin
        logic [W-1:0] v;
        @(negedge CLOCK_50);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_level", 32'(s_level), 0);
        chk("reset_flags", 32'({s_empty, s_full, s_ae, s_af}), 32'(4'b1010));
        chk("reset_out", 32'({s_dout, s_dv, s_ovf, s_udf}), 0);

        // Registered-read fill and drain.
        for (int i = 1; i <= 5; i++) step(1, W'(8'h11 * i), 0);
        chk("fill_full", 32'({s_full, s_level}), 32'({1'b1, 3'd5}));
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1);
            chk("drain_data", 32'({s_dv, s_dout}), 32'({1'b1, 8'(8'h11 * i)}));
        end
        step(0, 0, 0);
        chk("drain_end", 32'({s_dv, s_empty}), 32'(2'b01));

        // Wrap-around: pointers cross DEPTH-1 -> 0 repeatedly.
        v = 8'h00;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                step(1, v, 0);
                v = v + 8'd1;
                chk("wrap_level", 32'(s_level <= 3'd4), 1);
            end
            for (int i = 0; i < 4; i++) begin
                step(0, 0, 1);
                chk("wrap_order", 32'(s_dout), 32'(c * 4 + i));
            end
        end

        // Full boundary: concurrent write/read drops the write.
        for (int i = 1; i <= 5; i++) step(1, W'(i), 0);
        step(1, 8'hAA, 1);
        chk("full_wr_rd", 32'({s_level, s_ovf, s_dout}), 32'({3'd4, 1'b1, 8'h01}));
        step(0, 0, 0, 0, 1);
        chk("ovf_clear", 32'(s_ovf), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1);
            chk("no_aa", 32'(s_dout != 8'hAA), 1);
        end

        // Empty boundary.
        step(0, 0, 1);
        chk("udf_set", 32'({s_udf, s_level}), 32'({1'b1, 3'd0}));
        step(1, 8'h5A, 1);
        chk("empty_wr_rd", 32'({s_udf, s_level}), 32'({1'b1, 3'd1}));
        step(0, 0, 1);

        // FWFT visibility and pop.
        step(1, 8'h77, 0);
        chk("fwft_first", 32'({f_dout, f_dv, f_ae}), 32'({8'h77, 1'b1, 1'b1}));
        step(0, 0, 1);
        chk("fwft_pop", 32'({f_empty, f_dv}), 32'(2'b10));

        // Flush beats a coincident write; error flags untouched.
        for (int i = 0; i < 3; i++) step(1, W'(8'hC0 + i), 0);
        step(1, 8'hEE, 0, 1);
        chk("flush", 32'({s_level, s_empty, s_udf}), 32'({3'd0, 1'b1, 1'b1}));

        // Reset mid-burst.
        step(1, 8'h10, 0);
        step(1, 8'h11, 1);
        step(1, 8'h12, 1, 0, 0, 0);
        chk("rst_mid", 32'({s_level, s_dout, s_dv, s_ovf, s_udf, s_empty, s_af}),
            32'({3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 55, W'($urandom), $urandom_range(99) < 50,
                 $urandom_range(99) < 2, $urandom_range(99) < 5,
                 !($urandom_range(199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
